// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - request/response and data-memory bundle of the load/store unit
//
// Groups the core request channel (req_*), the completion channel (rsp_*) and
// the word-wide data memory port (mem_*).
//   slave  : the load/store unit (accepts requests, drives memory address/write)
//   master : the core plus data memory (issues requests, returns mem_rdata)
interface load_store_unit_if #(
    parameter int WIDTH = 32
);
    logic             req_valid;
    logic             req_ready;
    logic             req_we;
    logic [2:0]       req_funct3;
    logic [WIDTH-1:0] req_addr;
    logic [WIDTH-1:0] req_wdata;

    logic             rsp_valid;
    logic [WIDTH-1:0] rsp_rdata;
    logic             rsp_err;

    logic [WIDTH-1:0] mem_A;
    logic             mem_WE;
    logic [WIDTH-1:0] mem_wdata;
    logic [WIDTH-1:0] mem_rdata;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        output mem_A, mem_WE, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        input  mem_A, mem_WE, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I byte/half/word load-store unit over a word-wide data memory
//
// Ports:
//   clk  - clock, all state changes on the rising edge
//   rst  - asynchronous active-high reset
//   bus  - load_store_unit_if.slave:
//          req_valid/req_ready/req_we/req_funct3/req_addr/req_wdata  core request
//          rsp_valid/rsp_rdata/rsp_err                               one-cycle completion
//          mem_A/mem_WE/mem_wdata/mem_rdata                          word memory port
//
// Every access reads the addressed word first (RD); stores then write back the
// word with only the addressed lanes replaced (WR). Misaligned or illegal
// requests skip memory entirely and complete with rsp_err.
module load_store_unit #(
    parameter int WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    load_store_unit_if.slave      bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RSP  = 2'd3
    } state_t;

    state_t            state;
    logic              we_q;
    logic [2:0]        funct3_q;
    logic [1:0]        off_q;       // byte offset within the word
    logic [WIDTH-1:0]  wdata_q;
    logic [WIDTH-1:0]  word_q;      // word read in RD, base for the store merge

    logic              req_bad;

    // Legality and alignment of the request currently presented.
    always_comb begin
        req_bad = 1'b0;
        case (bus.req_funct3)
            3'b000:  req_bad = 1'b0;
            3'b001:  req_bad = bus.req_addr[0];
            3'b010:  req_bad = (bus.req_addr[1:0] != 2'b00);
            3'b100:  req_bad = bus.req_we;
            3'b101:  req_bad = bus.req_we | bus.req_addr[0];
            default: req_bad = 1'b1;
        endcase
    end

    function automatic logic [31:0] load_extract(input logic [31:0] w,
                                                 input logic [1:0]  off,
                                                 input logic [2:0]  f3);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = off[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b010:  r = w;
            3'b100:  r = {24'd0, b};
            3'b101:  r = {16'd0, h};
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] w,
                                                input logic [31:0] d,
                                                input logic [1:0]  off,
                                                input logic [2:0]  f3);
        logic [31:0] r;
        r = w;
        case (f3[1:0])
            2'b00: begin
                case (off)
                    2'd0:    r[7:0]   = d[7:0];
                    2'd1:    r[15:8]  = d[7:0];
                    2'd2:    r[23:16] = d[7:0];
                    default: r[31:24] = d[7:0];
                endcase
            end
            2'b01: begin
                if (off[1]) r[31:16] = d[15:0];
                else        r[15:0]  = d[15:0];
            end
            default: r = d;
        endcase
        return r;
    endfunction

    // The merged word is only presented while mem_WE is high; otherwise the
    // write-data bus idles at zero.
    assign bus.mem_wdata = bus.mem_WE ? store_merge(word_q, wdata_q, off_q, funct3_q) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            bus.req_ready <= 1'b1;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b0;
            bus.mem_WE    <= 1'b0;
            bus.mem_A     <= '0;
            we_q          <= 1'b0;
            funct3_q      <= 3'd0;
            off_q         <= 2'd0;
            wdata_q       <= '0;
            word_q        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        we_q          <= bus.req_we;
                        funct3_q      <= bus.req_funct3;
                        off_q         <= bus.req_addr[1:0];
                        wdata_q       <= bus.req_wdata;
                        bus.mem_A     <= {bus.req_addr[WIDTH-1:2], 2'b00};
                        bus.req_ready <= 1'b0;
                        if (req_bad) begin
                            state         <= RSP;
                            bus.rsp_valid <= 1'b1;
                            bus.rsp_err   <= 1'b1;
                            bus.rsp_rdata <= '0;
                        end else begin
                            state <= RD;
                        end
                    end
                end
                RD: begin
                    word_q <= bus.mem_rdata;
                    if (we_q) begin
                        state      <= WR;
                        bus.mem_WE <= 1'b1;
                    end else begin
                        state         <= RSP;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_rdata <= load_extract(bus.mem_rdata, off_q, funct3_q);
                    end
                end
                WR: begin
                    bus.mem_WE    <= 1'b0;
                    state         <= RSP;
                    bus.rsp_valid <= 1'b1;
                    bus.rsp_rdata <= '0;
                end
                default: begin
                    bus.rsp_valid <= 1'b0;
                    bus.rsp_err   <= 1'b0;
                    bus.rsp_rdata <= '0;
                    bus.req_ready <= 1'b1;
                    state         <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench for load_store_unit
module tb_load_store_unit;

    logic clk;
    logic rst;

    load_store_unit_if #(.WIDTH(32)) bus ();

    load_store_unit #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory: 256 words, combinational read, written by the DUT or by
    // the bench's own preload port.
    logic [31:0] dmem [0:255];
    logic        tb_we;
    logic [7:0]  tb_idx;
    logic [31:0] tb_data;

    assign bus.mem_rdata = dmem[bus.mem_A[9:2]];

    always @(posedge clk) begin
        if (tb_we)            dmem[tb_idx] <= tb_data;
        else if (bus.mem_WE)  dmem[bus.mem_A[9:2]] <= bus.mem_wdata;
    end

    // Reference model: byte-addressed memory image.
    logic [7:0] ref_bytes [0:1023];

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] model_word(input int a);
        int base;
        base = a & 32'h3FC;
        return {ref_bytes[base+3], ref_bytes[base+2], ref_bytes[base+1], ref_bytes[base]};
    endfunction

    function automatic int access_size(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic logic model_err(input logic we, input logic [2:0] f3, input logic [31:0] addr);
        logic legal;
        if (we) legal = (f3 < 3);
        else    legal = (f3 != 3 && f3 != 6 && f3 != 7);
        return !legal || ((addr % access_size(f3)) != 0);
    endfunction

    function automatic logic [31:0] model_load(input int a, input logic [2:0] f3);
        int v;
        case (f3)
            3'b000: begin v = int'(ref_bytes[a]); if (v >= 128) v -= 256; end
            3'b100: v = int'(ref_bytes[a]);
            3'b001: begin v = int'(ref_bytes[a]) + 256 * int'(ref_bytes[a+1]); if (v >= 32768) v -= 65536; end
            3'b101: v = int'(ref_bytes[a]) + 256 * int'(ref_bytes[a+1]);
            default: return model_word(a);
        endcase
        return 32'(v);
    endfunction

    task automatic model_store(input int a, input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] sh;
        sh = d;
        for (int i = 0; i < access_size(f3); i++) begin
            ref_bytes[a+i] = sh[7:0];
            sh = sh >> 8;
        end
    endtask

    // Issue one request and observe it until rsp_valid, counting cycles from
    // the accept edge.
    task automatic apply(input string name, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic exp_err, input logic [31:0] exp_rdata,
                         input logic [31:0] exp_wd, input int exp_lat);
        int          n;
        int          rsp_cyc;
        int          we_cnt;
        int          we_cyc;
        logic [31:0] we_a;
        logic [31:0] we_d;
        logic        got_err;
        logic [31:0] got_rdata;
        rsp_cyc = 0; we_cnt = 0; we_cyc = 0; we_a = 0; we_d = 0; got_err = 0; got_rdata = 0;
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        n = 0;
        while (!bus.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) bus.req_valid = 1'b0;
            if (bus.mem_WE) begin
                we_cnt++;
                we_cyc = c;
                we_a   = bus.mem_A;
                we_d   = bus.mem_wdata;
            end
            if (bus.rsp_valid) begin
                rsp_cyc   = c;
                got_err   = bus.rsp_err;
                got_rdata = bus.rsp_rdata;
                break;
            end
        end
        bus.req_valid = 1'b0;
        check({name, " latency"}, rsp_cyc, exp_lat);
        check({name, " rsp_err"}, got_err, exp_err);
        check({name, " rsp_rdata"}, got_rdata, exp_rdata);
        if (we && !exp_err) begin
            check({name, " we_count"}, we_cnt, 1);
            check({name, " we_cycle"}, we_cyc, 2);
            check({name, " mem_A"}, we_a, {addr[31:2], 2'b00});
            check({name, " mem_wdata"}, we_d, exp_wd);
        end else begin
            check({name, " we_count"}, we_cnt, 0);
        end
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_rdata;
        logic [31:0] exp_wd;
        int          exp_lat;
    } vec_t;

    vec_t vecs [0:14];

    initial begin
        logic [31:0] w;
        logic [31:0] r;
        logic [31:0] a;
        logic [31:0] d;
        logic        we;
        logic [2:0]  f3;
        logic        e;
        logic [31:0] er;
        logic [31:0] ewd;
        int          t1;
        int          t2;
        int          cnt_we;
        int          cnt_rsp;

        rst = 1'b1;
        tb_we = 1'b0; tb_idx = 0; tb_data = 0;
        bus.req_valid = 0; bus.req_we = 0; bus.req_funct3 = 0; bus.req_addr = 0; bus.req_wdata = 0;

        vecs[0]  = '{0, 3'b000, 32'h41, 0,            0, 32'hFFFFFFAA, 0, 2};
        vecs[1]  = '{0, 3'b101, 32'h42, 0,            0, 32'h00008899, 0, 2};
        vecs[2]  = '{0, 3'b001, 32'h42, 0,            0, 32'hFFFF8899, 0, 2};
        vecs[3]  = '{0, 3'b100, 32'h40, 0,            0, 32'h000000BB, 0, 2};
        vecs[4]  = '{0, 3'b010, 32'h40, 0,            0, 32'h8899AABB, 0, 2};
        vecs[5]  = '{1, 3'b010, 32'h40, 32'h11223344, 0, 0, 32'h11223344, 3};
        vecs[6]  = '{1, 3'b000, 32'h43, 32'h000000EE, 0, 0, 32'hEE223344, 3};
        vecs[7]  = '{0, 3'b010, 32'h40, 0,            0, 32'hEE223344, 0, 2};
        vecs[8]  = '{1, 3'b001, 32'h41, 32'h00005555, 1, 0, 0, 1};
        vecs[9]  = '{0, 3'b010, 32'h40, 0,            0, 32'hEE223344, 0, 2};
        vecs[10] = '{0, 3'b010, 32'h42, 0,            1, 0, 0, 1};
        vecs[11] = '{0, 3'b011, 32'h40, 0,            1, 0, 0, 1};
        vecs[12] = '{1, 3'b100, 32'h40, 32'h12345678, 1, 0, 0, 1};
        vecs[13] = '{1, 3'b001, 32'h80000042, 32'hFFFFCAFE, 0, 0, 32'hCAFE3344, 3};
        vecs[14] = '{0, 3'b001, 32'h42, 0,            0, 32'hFFFFCAFE, 0, 2};

        // Reset state and memory preload, DUT held in reset.
        @(negedge clk);
        check("reset req_ready", bus.req_ready, 1);
        check("reset rsp_valid", bus.rsp_valid, 0);
        check("reset rsp_err", bus.rsp_err, 0);
        check("reset rsp_rdata", bus.rsp_rdata, 0);
        check("reset mem_WE", bus.mem_WE, 0);
        check("reset mem_A", bus.mem_A, 0);
        check("reset mem_wdata", bus.mem_wdata, 0);
        for (int i = 0; i < 256; i++) begin
            w = (i == 16) ? 32'h8899AABB : (32'h9E3779B9 * (i + 1));
            ref_bytes[4*i]   = w[7:0];
            ref_bytes[4*i+1] = w[15:8];
            ref_bytes[4*i+2] = w[23:16];
            ref_bytes[4*i+3] = w[31:24];
            tb_we = 1'b1; tb_idx = 8'(i); tb_data = w;
            @(negedge clk);
        end
        tb_we = 1'b0;
        rst = 1'b0;

        // Directed vectors.
        for (int i = 0; i < 15; i++) begin
            apply($sformatf("vec%0d", i), vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata,
                  vecs[i].exp_err, vecs[i].exp_rdata, vecs[i].exp_wd, vecs[i].exp_lat);
            if (vecs[i].we && !vecs[i].exp_err)
                model_store(int'(vecs[i].addr[9:0]), vecs[i].f3, vecs[i].wdata);
        end

        // Reset during RD aborts a store.
        @(negedge clk);
        bus.req_valid = 1; bus.req_we = 1; bus.req_funct3 = 3'b010;
        bus.req_addr = 32'h40; bus.req_wdata = 32'hDEADBEEF;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 0;
        rst = 1'b1;
        #1;
        check("abort req_ready", bus.req_ready, 1);
        check("abort mem_WE", bus.mem_WE, 0);
        check("abort rsp_valid", bus.rsp_valid, 0);
        check("abort mem_A", bus.mem_A, 0);
        @(negedge clk);
        rst = 1'b0;
        cnt_we = 0; cnt_rsp = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (bus.mem_WE) cnt_we++;
            if (bus.rsp_valid) cnt_rsp++;
        end
        check("abort no write", cnt_we, 0);
        check("abort no rsp", cnt_rsp, 0);
        check("abort word kept", dmem[16], model_word(32'h40));
        apply("post_abort LW", 0, 3'b010, 32'h40, 0, 0, model_word(32'h40), 0, 2);

        // Back-to-back loads with req_valid held high.
        @(negedge clk);
        bus.req_valid = 1; bus.req_we = 0; bus.req_funct3 = 3'b010; bus.req_addr = 32'h40;
        t1 = -1; t2 = -1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                if (t1 < 0) begin
                    t1 = c;
                    check("b2b first rdata", bus.rsp_rdata, model_word(32'h40));
                    bus.req_addr = 32'h44;
                end else begin
                    t2 = c;
                    check("b2b second rdata", bus.rsp_rdata, model_word(32'h44));
                    break;
                end
            end
        end
        bus.req_valid = 0;
        check("b2b first latency", t1, 1);
        check("b2b gap", t2 - t1, 3);

        // Randomized requests against the byte-level model.
        for (int i = 0; i < 80; i++) begin
            r  = $urandom;
            we = r[0];
            f3 = r[3:1];
            a  = $urandom;
            if (r[4]) a[1:0] = 2'b00;
            if (r[5]) a[31:10] = 22'd0;
            d  = $urandom;
            e  = model_err(we, f3, a);
            er = (!e && !we) ? model_load(int'(a[9:0]), f3) : 32'd0;
            ewd = 32'd0;
            if (we && !e) begin
                model_store(int'(a[9:0]), f3, d);
                ewd = model_word(int'(a[9:0]));
            end
            apply($sformatf("rnd%0d", i), we, f3, a, d, e, er, ewd, e ? 1 : (we ? 3 : 2));
        end

        @(negedge clk);
        for (int i = 0; i < 256; i++)
            check($sformatf("final word%0d", i), dmem[i], model_word(4 * i));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The module SHALL have one parameter: WIDTH, default 32, data/address width; only 32 is supported.
REQ-002 The module SHALL have port clk  input  1  the only clock; all state changes on its rising edge.
REQ-003 The module SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 The module SHALL have port req_valid  input  1  core presents a memory request.
REQ-005 The module SHALL have port req_ready  output  1  unit accepts a request this cycle.
REQ-006 The module SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-007 The module SHALL have port req_funct3  input  3  RV32I width/sign code.
REQ-008 The module SHALL have port req_addr  input  WIDTH  byte address.
REQ-009 The module SHALL have port req_wdata  input  WIDTH  store data, right-aligned.
REQ-010 The module SHALL have port rsp_valid  output  1  one-cycle completion pulse.
REQ-011 The module SHALL have port rsp_rdata  output  WIDTH  extended load result; 0 for stores and errors.
REQ-012 The module SHALL have port rsp_err  output  1  request rejected: misaligned or illegal funct3; valid only with rsp_valid.
REQ-013 The module SHALL have port mem_A  output  WIDTH  word address to data memory, bits [1:0] always 00.
REQ-014 The module SHALL have port mem_WE  output  1  word write enable to data memory.
REQ-015 The module SHALL have port mem_wdata  output  WIDTH  merged word to data memory.
REQ-016 The module SHALL have port mem_rdata  input  WIDTH  combinational read word from data memory at mem_A, little-endian.

Function
REQ-017 The FSM SHALL have the states IDLE, RD, WR and RSP; req_ready SHALL be 1 only in IDLE.
REQ-018 In IDLE with req_valid=1, the unit SHALL latch addr, we, funct3 and wdata on the edge and register mem_A={addr[31:2],2'b00}.
REQ-019 Legal loads: funct3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
REQ-020 Legal stores: funct3 000 SB, 001 SH, 010 SW.
REQ-021 An accepted request SHALL be misaligned when it is halfword with addr[0]=1, or word with addr[1:0]!=00.
REQ-022 A misaligned or illegal request SHALL go IDLE->RSP with rsp_err=1 and rsp_rdata=0, and mem_WE SHALL never assert for it.
REQ-023 A legal request SHALL go IDLE->RD; in RD the unit SHALL capture mem_rdata into a word register.
REQ-024 From RD, a load SHALL go to RSP and a store SHALL go to WR.
REQ-025 In WR, mem_WE SHALL be 1 for exactly one cycle with mem_wdata equal to the captured word, with only the addressed byte lane(s) replaced:
- SB: byte addr[1:0] <= wdata[7:0];
- SH: lanes {addr[1],0} and {addr[1],1} <= wdata[15:0];
- SW: full word.
The FSM SHALL then go to RSP.
REQ-026 In RSP, rsp_valid SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-027 Load result: select the byte or halfword at addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word unchanged.
REQ-028 rsp_rdata SHALL be registered and stable through the RSP cycle.
REQ-029 Latency, counting the accept edge as edge 0:
- load: rsp_valid high in cycle 2;
- store: mem_WE high in cycle 2, rsp_valid high in cycle 3;
- error: rsp_valid high in cycle 1.
REQ-030 Outside WR, mem_WE SHALL be 0 and mem_wdata SHALL be 0.
REQ-031 req_valid SHALL be ignored outside IDLE; the request SHALL NOT be queued, and the core holds it until req_ready.
REQ-032 Back-to-back operation: a new request SHALL be accepted in the IDLE cycle immediately following RSP; throughput is one load per 3 cycles and one store per 4 cycles.
REQ-033 Address bits above the memory depth SHALL pass through unmodified; wrap-around is the memory's concern.

Reset
REQ-034 While rst=1, the unit SHALL immediately force:
- state IDLE, req_ready=1;
- rsp_valid=0, rsp_rdata=0, rsp_err=0;
- mem_WE=0, mem_A=0, mem_wdata=0;
- all latched request fields 0.
REQ-035 Reset asserted in RD or WR SHALL abort the operation: no write and no rsp_valid SHALL occur after reset release, and the first post-reset request SHALL be served normally.

Verification
REQ-036 Word 0x40 = 0x8899AABB; LB addr 0x41 -> rsp_valid in cycle 2, rsp_rdata=0xFFFFFFAA, rsp_err=0.
REQ-037 Same word; LHU addr 0x42 -> rsp_rdata=0x00008899; LH addr 0x42 -> 0xFFFF8899.
REQ-038 Word 0x40 = 0x11223344; SB addr 0x43, wdata=0x000000EE -> mem_WE high one cycle with mem_A=0x40 and mem_wdata=0xEE223344; rsp_valid in cycle 3; subsequent LW 0x40 returns 0xEE223344.
REQ-039 SH addr 0x41 -> rsp_err=1 in cycle 1, mem_WE never asserted, memory unchanged.
REQ-040 SW addr 0x40, data 0xDEADBEEF; assert rst during the RD cycle -> mem_WE stays 0, word 0x40 keeps its old value, req_ready=1 after release.
REQ-041 Loads to 0x40 and 0x44 with req_valid held high -> second accepted in the cycle after the first rsp_valid; the two responses are 3 cycles apart.
